rr_control_merge: RTL and testbench

Round-robin control merge with one-slot output buffering: accepts one token per cycle from SIZE data input channels, forwards its data on `outs`, and emits the winning input number on a separate `index` channel. Its `index` channel feeds the `index` port of a downstream `mux`, so that the mux is sequenced in the same order in which tokens were merged. Both outputs are eagerly forked, so each consumer may take its copy independently.

---
 rtl/rr_control_merge_pkg.sv | 19 +
 rtl/rr_control_merge_if.sv | 26 ++
 rtl/rr_control_merge_rr_arbiter.sv | 35 +++
 rtl/rr_control_merge.sv | 104 ++++++++++
 tb/tb_rr_control_merge.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/rr_control_merge_pkg.sv
// Shared handshake helpers: elaboration-time clog2 and the pending-flag part of the merge slot record.
package handshake_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(value)) begin
            w++;
        end
        return w;
    endfunction

    // One flag per eagerly forked copy still owed to its consumer.
    typedef struct packed {
        logic pend_o;
        logic pend_i;
    } pend_t;

endpackage

// File: rtl/rr_control_merge_if.sv
// Handshake bundle of rr_control_merge: SIZE input channels plus forked data and index outputs.
interface rr_control_merge_if #(
    parameter int unsigned SIZE        = 2,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH = 1
);
    logic [SIZE*DATA_WIDTH-1:0] ins;
    logic [SIZE-1:0]            ins_valid;
    logic [SIZE-1:0]            ins_ready;
    logic [DATA_WIDTH-1:0]      outs;
    logic                       outs_valid;
    logic                       outs_ready;
    logic [INDEX_WIDTH-1:0]     index;
    logic                       index_valid;
    logic                       index_ready;

    modport master (
        output ins, ins_valid, outs_ready, index_ready,
        input  ins_ready, outs, outs_valid, index, index_valid
    );

    modport slave (
        input  ins, ins_valid, outs_ready, index_ready,
        output ins_ready, outs, outs_valid, index, index_valid
    );
endinterface

// File: rtl/rr_control_merge_rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after i_ptr, wrapping modulo SIZE.
module rr_arbiter
    import handshake_pkg::*;
#(
    parameter int unsigned SIZE = 2
)(
    input  logic [SIZE-1:0]        i_req,
    input  logic [clog2(SIZE)-1:0] i_ptr,
    output logic [SIZE-1:0]        o_grant_oh,
    output logic [clog2(SIZE)-1:0] o_grant_idx
);
    localparam int unsigned PTR_W = clog2(SIZE);

    logic [PTR_W:0] w_sum;
    logic           w_found;

    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_sum       = '0;
        for (int unsigned k = 0; k < SIZE; k++) begin
            // ptr + k never exceeds 2*SIZE-2, so one conditional subtract is the modulo.
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(SIZE)) begin
                w_sum = w_sum - (PTR_W+1)'(SIZE);
            end
            if (!w_found && i_req[w_sum[PTR_W-1:0]]) begin
                w_found                      = 1'b1;
                o_grant_idx                  = w_sum[PTR_W-1:0];
                o_grant_oh[w_sum[PTR_W-1:0]] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_control_merge.sv
// Control merge of SIZE channels into a one-slot buffer whose data and winning index are forked eagerly.
// RR_CONTROL_MERGE_ROUND_ROBIN_EN selects rotating priority; undefined gives fixed lowest-index priority.
module rr_control_merge
    import handshake_pkg::*;
#(
    parameter int unsigned SIZE        = 2,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH = 1
)(
    input  logic              clk,
    input  logic              rst,
    rr_control_merge_if.slave bus
);
    localparam int unsigned PTR_W = clog2(SIZE);

    if (SIZE < 2) begin : g_bad_size
        $error("rr_control_merge: SIZE must be at least 2");
    end
    if (INDEX_WIDTH < PTR_W) begin : g_bad_index
        $error("rr_control_merge: INDEX_WIDTH is narrower than clog2(SIZE)");
    end

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [INDEX_WIDTH-1:0] idx;
        pend_t                  pend;
    } slot_t;

    slot_t                 r_slot;
    logic [PTR_W-1:0]      w_ptr;
    logic [SIZE-1:0]       w_grant_oh;
    logic [PTR_W-1:0]      w_grant_idx;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_free;
    logic                  w_accept;

    rr_arbiter #(
        .SIZE (SIZE)
    ) u_arbiter (
        .i_req       (bus.ins_valid),
        .i_ptr       (w_ptr),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx)
    );

    // Gated by rst so no channel sees ready while the block is held in reset.
    assign w_free   = rst
                    & (!r_slot.pend.pend_o | bus.outs_ready)
                    & (!r_slot.pend.pend_i | bus.index_ready);
    assign w_accept = w_free & (|bus.ins_valid);

    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_data = bus.ins[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot <= '0;
        end else if (w_accept) begin
            r_slot.data        <= w_sel_data;
            r_slot.idx         <= INDEX_WIDTH'(w_grant_idx);
            r_slot.pend.pend_o <= 1'b1;
            r_slot.pend.pend_i <= 1'b1;
        end else if (w_free) begin
            r_slot.pend <= '0;
        end else begin
            if (bus.outs_ready) begin
                r_slot.pend.pend_o <= 1'b0;
            end
            if (bus.index_ready) begin
                r_slot.pend.pend_i <= 1'b0;
            end
        end
    end

`ifdef RR_CONTROL_MERGE_ROUND_ROBIN_EN
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;

    assign w_ptr_next = (w_grant_idx == PTR_W'(SIZE - 1)) ? '0 : w_grant_idx + 1'b1;
    assign w_ptr      = r_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= w_ptr_next;
        end
    end
`else
    assign w_ptr = '0;
`endif

    assign bus.ins_ready   = w_grant_oh & {SIZE{w_free}};
    assign bus.outs        = r_slot.data;
    assign bus.outs_valid  = r_slot.pend.pend_o;
    assign bus.index       = r_slot.idx;
    assign bus.index_valid = r_slot.pend.pend_i;
endmodule

// File: tb/tb_rr_control_merge.sv
// Directed bench for rr_control_merge: a SIZE=2 instance and a SIZE=3 instance sharing clock and reset.
module tb_rr_control_merge;
`ifdef RR_CONTROL_MERGE_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    rr_control_merge_if #(.SIZE(2), .DATA_WIDTH(32), .INDEX_WIDTH(1)) bus2 ();
    rr_control_merge_if #(.SIZE(3), .DATA_WIDTH(8),  .INDEX_WIDTH(2)) bus3 ();

    rr_control_merge #(.SIZE(2), .DATA_WIDTH(32), .INDEX_WIDTH(1)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    rr_control_merge #(.SIZE(3), .DATA_WIDTH(8), .INDEX_WIDTH(2)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus2.ins         = {32'hB, 32'hA};
        bus2.ins_valid   = 2'b11;
        bus2.outs_ready  = 1'b1;
        bus2.index_ready = 1'b1;
        bus3.ins         = '0;
        bus3.ins_valid   = 3'b000;
        bus3.outs_ready  = 1'b1;
        bus3.index_ready = 1'b1;
        #2 rst = 1'b0;

        // Reset held three cycles with both inputs valid.
        repeat (3) after_edge();
        check("rst_outs_valid",  32'(bus2.outs_valid),  32'd0);
        check("rst_index_valid", 32'(bus2.index_valid), 32'd0);
        check("rst_outs",        32'(bus2.outs),        32'd0);
        check("rst_index",       32'(bus2.index),       32'd0);
        check("rst_ins_ready",   32'(bus2.ins_ready),   32'd0);

        // Contention: both valid, both consumers ready, one token per cycle.
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cont_ins_ready", 32'(bus2.ins_ready), (RR && (k % 2 == 1)) ? 32'd2 : 32'd1);
            after_edge();
            check("cont_index", 32'(bus2.index),      (RR && (k % 2 == 1)) ? 32'd1 : 32'd0);
            check("cont_outs",  32'(bus2.outs),       (RR && (k % 2 == 1)) ? 32'hB : 32'hA);
            check("cont_valid", 32'(bus2.outs_valid), 32'd1);
            @(negedge clk);
        end

        // Split stall: accept 0x55 from channel 1, then the index consumer stalls.
        bus2.ins       = {32'h55, 32'h66};
        bus2.ins_valid = 2'b10;
        #1;
        check("split_ins_ready_acc", 32'(bus2.ins_ready), 32'd2);
        after_edge();
        check("split_outs",  32'(bus2.outs),  32'h55);
        check("split_index", 32'(bus2.index), 32'd1);
        @(negedge clk);
        bus2.ins_valid   = 2'b01;
        bus2.index_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("stall_ins_ready", 32'(bus2.ins_ready), 32'd0);
            after_edge();
            check("stall_outs_valid",  32'(bus2.outs_valid),  32'd0);
            check("stall_index_valid", 32'(bus2.index_valid), 32'd1);
            check("stall_index",       32'(bus2.index),       32'd1);
            check("stall_outs",        32'(bus2.outs),        32'h55);
            @(negedge clk);
        end
        bus2.index_ready = 1'b1;
        #1;
        check("unstall_ins_ready", 32'(bus2.ins_ready), 32'd1);
        after_edge();
        check("unstall_outs",        32'(bus2.outs),        32'h66);
        check("unstall_index",       32'(bus2.index),       32'd0);
        check("unstall_outs_valid",  32'(bus2.outs_valid),  32'd1);
        check("unstall_index_valid", 32'(bus2.index_valid), 32'd1);

        // Mid-operation reset discards the held token.
        @(negedge clk);
        bus2.ins_valid   = 2'b00;
        bus2.outs_ready  = 1'b0;
        bus2.index_ready = 1'b0;
        after_edge();
        check("hold_outs_valid", 32'(bus2.outs_valid), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("async_outs_valid",  32'(bus2.outs_valid),  32'd0);
        check("async_index_valid", 32'(bus2.index_valid), 32'd0);
        check("async_outs",        32'(bus2.outs),        32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus2.outs_ready  = 1'b1;
        bus2.index_ready = 1'b1;
        after_edge();
        check("post_rst_outs_valid",  32'(bus2.outs_valid),  32'd0);
        check("post_rst_index_valid", 32'(bus2.index_valid), 32'd0);

        // SIZE=3 wrap-around: move ptr to 2 via channel 1, then channels 0 and 2 compete.
        @(negedge clk);
        bus3.ins       = {8'h22, 8'h11, 8'h20};
        bus3.ins_valid = 3'b010;
        #1;
        check("wrap_ins_ready_a", 32'(bus3.ins_ready), 32'd2);
        after_edge();
        check("wrap_index_a", 32'(bus3.index), 32'd1);
        check("wrap_outs_a",  32'(bus3.outs),  32'h11);
        @(negedge clk);
        bus3.ins_valid = 3'b101;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("wrap_ins_ready", 32'(bus3.ins_ready), (RR && k != 1) ? 32'd4 : 32'd1);
            after_edge();
            check("wrap_index", 32'(bus3.index), (RR && k != 1) ? 32'd2 : 32'd0);
            check("wrap_outs",  32'(bus3.outs),  (RR && k != 1) ? 32'h22 : 32'h20);
            @(negedge clk);
        end
        bus3.ins_valid = 3'b000;
        after_edge();
        check("idle_outs_valid", 32'(bus3.outs_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end
endmodule
